add_sub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor with a start/busy/done handshake. It processes `DIGIT` operand bits per clock and reports carry and signed overflow. It is the sequential, width-generic successor to the 4-bit combinational add/sub unit and serves datapaths that trade latency for area.

---
 rtl/add_sub_serial_if.sv | 25 ++
 rtl/add_sub_serial.sv | 131 +++++++++++++
 tb/tb_add_sub_serial.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_serial_if.sv
// add_sub_serial_if: start/busy/done handshake and operand/result bus
// master drives start/a/b/control; slave returns busy/done/result/cout/ovf
interface add_sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             control;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, control,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, a, b, control,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial two's-complement add/sub, DIGIT bits per clk
// ports: clk, rst_n (async low), bus (slave); ADD_SUB_SATURATE_EN clamps on ovf
module add_sub_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic            clk,
  input logic            rst_n,
  add_sub_serial_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DIGIT + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT:0]   sum;
  logic             cin_msb;
  logic             ovf_w;
  logic             last;

  assign sum = {1'b0, a_q[DIGIT-1:0]}
             + {1'b0, b_q[DIGIT-1:0]}
             + SW'(carry_q);

  // sum bit = a ^ b ^ cin, so the carry into the top bit
  // of this digit falls out without a second adder
  assign cin_msb = sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign ovf_w   = cin_msb ^ sum[DIGIT];
  assign last    = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.control}};
          carry_d = bus.control;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d   = WIDTH'({sum[DIGIT-1:0], acc_q} >> DIGIT);
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = sum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cout_d  = sum[DIGIT];
          ovf_d   = ovf_w;
`ifdef ADD_SUB_SATURATE_EN
          // a_q[DIGIT-1] now holds the original sign of a
          if (ovf_w) begin
            result_d = a_q[DIGIT-1]
                     ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            result_d = acc_d;
          end
`else
          result_d = acc_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// tb_add_sub_serial: vector table, random ops vs arithmetic model,
// streaming and reset-in-run sequences for add_sub_serial (W=8, D=2)
module tb_add_sub_serial;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

`ifdef ADD_SUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  add_sub_serial_if #(.WIDTH(W)) bus ();

  add_sub_serial #(
    .WIDTH(W),
    .DIGIT(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ctl;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // {result, cout, ovf} from signed/unsigned integer arithmetic
  function automatic logic [9:0] model(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic ctl);
    int ua;
    int ub;
    int sa;
    int sb;
    int us;
    int ss;
    logic [7:0] r;
    logic co;
    logic ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (ctl) begin
      us = ua - ub;
      ss = sa - sb;
      co = (ua >= ub);
    end else begin
      us = ua + ub;
      ss = sa + sb;
      co = (us > 255);
    end
    r  = us[7:0];
    ov = (ss > 127) || (ss < -128);
    if (SAT && ov) r = (ss > 127) ? 8'h7F : 8'h80;
    return {r, co, ov};
  endfunction

  task automatic do_op(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic ctl,
                       output int lat);
    int bad;
    bad = 0;
    bus.a = a;
    bus.b = b;
    bus.control = ctl;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    bus.control = ~ctl;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_during_run", 32'(bad), 32'd0);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  int prev_done;
  int ndone;
  logic [9:0] q[$];

  task automatic stream_obs(input int c);
    logic [9:0] e;
    if (bus.done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        chk("stream_extra_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("stream_res",
            32'({bus.result, bus.cout, bus.ovf}), 32'(e));
      end
      if (prev_done >= 0) chk("stream_period", 32'(c - prev_done), 32'd5);
      prev_done = c;
    end
  endtask

  vec_t vt[7];

  initial begin
    int lat;
    int nd;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;
    logic [9:0] e;

    vt[0] = '{8'd25,  8'd17,  1'b0, 8'd42,  1'b0, 1'b0};
    vt[1] = '{8'd17,  8'd25,  1'b1, 8'hF8,  1'b0, 1'b0};
    vt[2] = '{8'd255, 8'd1,   1'b0, 8'h00,  1'b1, 1'b0};
    vt[3] = '{8'd100, 8'd100, 1'b0, SAT ? 8'h7F : 8'hC8, 1'b0, 1'b1};
    vt[4] = '{8'h80,  8'd1,   1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
    vt[5] = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
    vt[6] = '{8'h7F,  8'h01,  1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.control = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_cout",   32'(bus.cout),   32'd0);
    chk("rst_ovf",    32'(bus.ovf),    32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].ctl, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(N));
      chk($sformatf("vec%0d_res", i), 32'(bus.result), 32'(vt[i].res));
      chk($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vt[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vt[i].ov));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_width", i), 32'(bus.done), 32'd0);
      chk($sformatf("vec%0d_held", i), 32'(bus.result), 32'(vt[i].res));
    end

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e = model(ra, rb, rc);
      do_op(ra, rb, rc, lat);
      chk("rand_lat", 32'(lat), 32'(N));
      chk("rand_out", 32'({bus.result, bus.cout, bus.ovf}), 32'(e));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    prev_done = -1;
    ndone = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      stream_obs(c);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.control = 1'($urandom);
      if (bus.busy === 1'b0) q.push_back(model(bus.a, bus.b, bus.control));
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    for (int c = 40; c < 50; c++) begin
      stream_obs(c);
      @(posedge clk);
      #1;
    end
    chk("stream_count", 32'(ndone >= 8), 32'd1);
    chk("stream_drained", 32'(q.size()), 32'd0);

    do_op(8'h80, 8'h01, 1'b1, lat);
    do_op(8'h55, 8'h11, 1'b0, lat);
    bus.a = 8'h55;
    bus.b = 8'h33;
    bus.control = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(bus.busy),   32'd0);
    chk("mid_rst_done",   32'(bus.done),   32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_cout",   32'(bus.cout),   32'd0);
    chk("mid_rst_ovf",    32'(bus.ovf),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
      @(posedge clk);
      #1;
    end
    chk("post_rst_quiet", 32'(nd), 32'd0);
    do_op(8'd3, 8'd4, 1'b0, lat);
    chk("post_rst_lat", 32'(lat), 32'(N));
    chk("post_rst_res", 32'(bus.result), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
